// File: rtl/jalr_target_queue.sv
// In-order queue of pending JALR instructions; snoops NUM_CDB result buses to resolve the base operand
// and presents the head's computed target and mispredict flag to commit.
module jalr_target_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_CDB = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enq_valid,
  input  logic [TAG_W-1:0]           i_enq_tag,
  input  logic [XLEN-1:0]            i_enq_base,
  input  logic [XLEN-1:0]            i_enq_imm,
  input  logic [XLEN-1:0]            i_enq_pred_target,
  output logic                       o_enq_ready,
  input  logic [NUM_CDB-1:0]         i_cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   i_cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    i_cdb_result,
  input  logic [NUM_CDB-1:0]         i_cdb_load_step1,
  input  logic                       i_deq_en,
  input  logic                       i_flush,
  output logic                       o_head_valid,
  output logic                       o_head_ready,
  output logic [XLEN-1:0]            o_head_target,
  output logic [XLEN-1:0]            o_head_pred_target,
  output logic                       o_head_mispredict,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_vld;
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [XLEN-1:0]  r_base [DEPTH];
  logic [XLEN-1:0]  r_imm  [DEPTH];
  logic [XLEN-1:0]  r_pred [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  logic             w_port_live [NUM_CDB];
  logic [TAG_W-1:0] w_port_tag  [NUM_CDB];
  logic [XLEN-1:0]  w_port_res  [NUM_CDB];
  logic [DEPTH-1:0] w_ent_hit;
  logic [XLEN-1:0]  w_ent_res   [DEPTH];
  logic             w_enq_hit;
  logic [XLEN-1:0]  w_enq_res;
  logic             w_enq;
  logic             w_deq;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [XLEN-1:0]  w_head_sum;

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      w_port_live[p] = i_cdb_valid[p] & ~i_cdb_load_step1[p];
      w_port_tag[p]  = i_cdb_tag[p*TAG_W +: TAG_W];
      w_port_res[p]  = i_cdb_result[p*XLEN +: XLEN];
    end
  end

  // Scan ports high to low so the lowest matching index is the last assignment and wins.
  always_comb begin
    w_enq_hit = 1'b0;
    w_enq_res = '0;
    for (int p = NUM_CDB-1; p >= 0; p--) begin
      if (w_port_live[p] && (i_enq_tag != '0) && (w_port_tag[p] == i_enq_tag)) begin
        w_enq_hit = 1'b1;
        w_enq_res = w_port_res[p];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ent_hit[i] = 1'b0;
      w_ent_res[i] = '0;
      for (int p = NUM_CDB-1; p >= 0; p--) begin
        if (r_vld[i] && w_port_live[p] && (r_tag[i] != '0) && (w_port_tag[p] == r_tag[i])) begin
          w_ent_hit[i] = 1'b1;
          w_ent_res[i] = w_port_res[p];
        end
      end
    end
  end

  assign o_enq_ready  = (r_count != CNT_W'(DEPTH));
  assign o_head_valid = (r_count != '0);
  assign o_head_ready = o_head_valid && (r_tag[r_rptr] == '0);
  assign w_enq        = i_enq_valid && o_enq_ready;
  assign w_deq        = i_deq_en && o_head_ready;
  assign w_rptr_nxt   = (r_rptr == PTR_W'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
  assign w_wptr_nxt   = (r_wptr == PTR_W'(DEPTH-1)) ? '0 : r_wptr + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_deq) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= w_rptr_nxt;
      end
      if (w_enq) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= w_wptr_nxt;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Payload needs no reset: r_vld and r_count alone decide what is live.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_hit[i]) begin
        r_tag[i]  <= '0;
        r_base[i] <= w_ent_res[i];
      end
    end
    if (w_enq) begin
      r_tag[r_wptr]  <= w_enq_hit ? '0 : i_enq_tag;
      r_base[r_wptr] <= w_enq_hit ? w_enq_res : i_enq_base;
      r_imm[r_wptr]  <= i_enq_imm;
      r_pred[r_wptr] <= i_enq_pred_target;
    end
  end

  assign w_head_sum         = r_base[r_rptr] + r_imm[r_rptr];
  assign o_head_target      = {w_head_sum[XLEN-1:1], 1'b0};
  assign o_head_pred_target = r_pred[r_rptr];
  assign o_head_mispredict  = o_head_ready && (o_head_target != o_head_pred_target);
  assign o_count            = r_count;

endmodule

// File: tb/tb_jalr_target_queue.sv
// Scoreboard bench for jalr_target_queue (DEPTH=4, NUM_CDB=2): expected targets queued at enqueue, compared at dequeue.
module tb_jalr_target_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic [3:0]  enq_tag;
  logic [31:0] enq_base, enq_imm, enq_pred_target;
  logic        enq_ready;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_result;
  logic [1:0]  cdb_load_step1;
  logic        deq_en, flush;
  logic        head_valid, head_ready, head_mispredict;
  logic [31:0] head_target, head_pred_target;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] pred;
  } exp_t;

  exp_t sb[$];
  int   m_count  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  jalr_target_queue #(.DEPTH(4), .TAG_W(4), .XLEN(32), .NUM_CDB(2)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_enq_valid(enq_valid), .i_enq_tag(enq_tag), .i_enq_base(enq_base),
    .i_enq_imm(enq_imm), .i_enq_pred_target(enq_pred_target), .o_enq_ready(enq_ready),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_result(cdb_result),
    .i_cdb_load_step1(cdb_load_step1), .i_deq_en(deq_en), .i_flush(flush),
    .o_head_valid(head_valid), .o_head_ready(head_ready), .o_head_target(head_target),
    .o_head_pred_target(head_pred_target), .o_head_mispredict(head_mispredict), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0; cdb_tag = '0; cdb_result = '0; cdb_load_step1 = '0;
  endtask

  task automatic drive_enq(input logic [3:0] tag, input logic [31:0] base, input logic [31:0] imm,
                           input logic [31:0] pred, input logic [31:0] exp_tgt);
    exp_t e;
    bit   acc;
    acc = (m_count != 4);
    n_checks++;
    if (enq_ready !== acc) begin
      n_errors++; $display("FAIL enq_ready: got %b expected %b", enq_ready, acc);
    end
    enq_valid = 1'b1; enq_tag = tag; enq_base = base; enq_imm = imm; enq_pred_target = pred;
    if (acc) begin
      e.tgt = exp_tgt; e.pred = pred; sb.push_back(e);
    end
    tick();
    enq_valid = 1'b0;
    if (acc) m_count++;
  endtask

  task automatic drive_deq(input string name);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++; $display("FAIL %s: scoreboard empty at dequeue", name);
      return;
    end
    e = sb.pop_front();
    if (head_valid !== 1'b1 || head_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s head_rdy: got vld=%b rdy=%b expected 1 1", name, head_valid, head_ready);
    end
    n_checks++;
    if (head_target !== e.tgt) begin
      n_errors++; $display("FAIL %s target: got %h expected %h", name, head_target, e.tgt);
    end
    n_checks++;
    if (head_mispredict !== (e.tgt != e.pred)) begin
      n_errors++; $display("FAIL %s mispredict: got %b expected %b", name, head_mispredict, e.tgt != e.pred);
    end
    deq_en = 1'b1;
    tick();
    deq_en = 1'b0;
    m_count--;
  endtask

  task automatic check_count(input string name);
    n_checks++;
    if (count !== 3'(m_count)) begin
      n_errors++; $display("FAIL %s count: got %0d expected %0d", name, count, m_count);
    end
  endtask

  task automatic check_empty(input string name);
    n_checks++;
    if (count !== 3'd0 || head_valid !== 1'b0 || head_ready !== 1'b0 ||
        head_mispredict !== 1'b0 || enq_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: got cnt=%0d hv=%b hr=%b mp=%b er=%b expected 0 0 0 0 1",
               name, count, head_valid, head_ready, head_mispredict, enq_ready);
    end
  endtask

  task automatic check_unready(input string name);
    n_checks++;
    if (head_valid !== 1'b1 || head_ready !== 1'b0 || head_mispredict !== 1'b0) begin
      n_errors++; $display("FAIL %s: got hv=%b hr=%b mp=%b expected 1 0 0", name, head_valid, head_ready, head_mispredict);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enq_valid = 0; enq_tag = 0; enq_base = 0; enq_imm = 0; enq_pred_target = 0;
    deq_en = 0; flush = 0; clear_cdb();
    tick(); tick();
    reset = 1'b0;
    check_empty("reset");
  endtask

  task automatic test_ready_enq();
    drive_enq(4'd0, 32'h1000, 32'h11, 32'h1010, 32'h1010);
    check_count("ready_enq");
    drive_deq("ready_enq");
    check_count("ready_enq_drain");
  endtask

  task automatic test_cdb_resolve();
    drive_enq(4'd5, 32'hdead_beef, 32'h0, 32'h2000, 32'h3000);
    check_unready("cdb_wait");
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_result = {32'h0, 32'h4444}; cdb_load_step1 = 2'b01;
    tick(); clear_cdb();
    check_unready("cdb_load_step1");
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_result = {32'h0, 32'h3000};
    tick(); clear_cdb();
    drive_deq("cdb_resolve");
  endtask

  task automatic test_bypass();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd3}; cdb_result = {32'h0, 32'h40};
    drive_enq(4'd3, 32'h0bad, 32'h0, 32'h40, 32'h40);
    clear_cdb();
    drive_deq("bypass");
  endtask

  task automatic test_full_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] t;
        t = 32'h8000 + 32'(pass * 16'h100) + 32'(i * 8);
        drive_enq(4'd0, t | 32'h1, 32'h0, (i == 2) ? (t ^ 32'h4) : t, t);
      end
      check_count("full");
      drive_enq(4'd0, 32'h9999, 32'h0, 32'h9998, 32'h9998);
      check_count("full_drop");
      for (int i = 0; i < 4; i++) drive_deq("full_order");
      check_count("full_drained");
    end
  endtask

  task automatic test_deq_unready_and_simul();
    exp_t e;
    drive_enq(4'd7, 32'h0, 32'h4, 32'h504, 32'h504);
    deq_en = 1'b1; tick(); deq_en = 1'b0;
    check_count("deq_unready");
    check_unready("deq_unready_head");
    drive_enq(4'd0, 32'h601, 32'h0, 32'h600, 32'h600);
    cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_result = {32'h500, 32'h0};
    tick(); clear_cdb();
    // Enqueue and dequeue in one cycle at count 2.
    e = sb.pop_front();
    n_checks++;
    if (head_ready !== 1'b1 || head_target !== e.tgt) begin
      n_errors++; $display("FAIL simul head: got rdy=%b tgt=%h expected 1 %h", head_ready, head_target, e.tgt);
    end
    enq_valid = 1'b1; enq_tag = 4'd0; enq_base = 32'h700; enq_imm = 32'h0; enq_pred_target = 32'h0;
    e.tgt = 32'h700; e.pred = 32'h0; sb.push_back(e);
    deq_en = 1'b1;
    tick();
    enq_valid = 1'b0; deq_en = 1'b0;
    check_count("simul");
    drive_deq("simul_b");
    drive_deq("simul_c");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_enq(4'd0, 32'h10 * (i + 1), 32'h0, 32'h0, 32'h10 * (i + 1));
    check_count("pre_flush");
    flush = 1'b1; enq_valid = 1'b1; enq_tag = 4'd0; enq_base = 32'h55;
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    sb.delete(); m_count = 0;
    check_empty("flush");
    drive_enq(4'd0, 32'h20, 32'h0, 32'h20, 32'h20);
    drive_enq(4'd6, 32'h0, 32'h0, 32'h30, 32'h30);
    reset = 1'b1; enq_valid = 1'b1; enq_tag = 4'd0; deq_en = 1'b1;
    tick();
    reset = 1'b0; enq_valid = 1'b0; deq_en = 1'b0;
    sb.delete(); m_count = 0;
    check_empty("mid_reset");
    drive_enq(4'd0, 32'h1234, 32'h2, 32'h1236, 32'h1236);
    drive_deq("post_reset");
  endtask

  task automatic test_multi_cdb();
    drive_enq(4'd9, 32'h0, 32'h0, 32'h700, 32'h700);
    cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_result = {32'h900, 32'h700};
    tick(); clear_cdb();
    drive_deq("multi_cdb_snoop");
    cdb_valid = 2'b11; cdb_tag = {4'd10, 4'd10}; cdb_result = {32'hB00, 32'hA00};
    drive_enq(4'd10, 32'h0, 32'h0, 32'hA00, 32'hA00);
    clear_cdb();
    drive_deq("multi_cdb_bypass");
    drive_enq(4'd11, 32'h0, 32'h0, 32'hC00, 32'hC00);
    cdb_valid = 2'b11; cdb_tag = {4'd11, 4'd11}; cdb_result = {32'hC00, 32'hD00}; cdb_load_step1 = 2'b01;
    tick(); clear_cdb();
    drive_deq("multi_cdb_step1_port1");
  endtask

  initial begin
    test_reset();
    test_ready_enq();
    test_cdb_resolve();
    test_bypass();
    test_full_wrap();
    test_deq_unready_and_simul();
    test_flush();
    test_multi_cdb();
    check_count("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
